// File: rtl/arm_pkg.sv
// Shared definitions for the fetch stage and its downstream controller.
//   - sel_pc redirect-source encodings
//   - fetch FSM state type
//   - instruction field bit positions
//   - decode_opcode(): instruction word -> 7-bit opcode class used by decode
package arm_pkg;

  // Redirect source encodings on sel_pc; SelRsvd behaves like SelNone.
  localparam logic [1:0] SelNone   = 2'd0;
  localparam logic [1:0] SelStart  = 2'd1;
  localparam logic [1:0] SelBranch = 2'd2;
  localparam logic [1:0] SelRsvd   = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StF1   = 2'd1,
    StF2   = 2'd2
  } fetch_state_t;

  // Instruction field bit positions.
  localparam int unsigned CondHi  = 31;
  localparam int unsigned CondLo  = 28;
  localparam int unsigned ClassHi = 27;
  localparam int unsigned ClassLo = 26;
  localparam int unsigned IBit    = 25;
  localparam int unsigned PBit    = 24;
  localparam int unsigned UBit    = 23;
  localparam int unsigned BBit    = 22;
  localparam int unsigned WBit    = 21;
  localparam int unsigned SBit    = 20;
  localparam int unsigned RnHi    = 19;
  localparam int unsigned RnLo    = 16;
  localparam int unsigned RdHi    = 15;
  localparam int unsigned RdLo    = 12;
  localparam int unsigned RsHi    = 11;
  localparam int unsigned RsLo    = 8;
  localparam int unsigned ShHi    = 6;
  localparam int unsigned ShLo    = 5;
  localparam int unsigned RmHi    = 3;
  localparam int unsigned RmLo    = 0;

  // Opcode layout: [6:5] instruction class, [4:0] class-specific detail.
  //   00: data processing  -> {I, opc[3:0]}
  //   01: load/store       -> {I, P, U, B, L}
  //   10: branch           -> {I, L, 3'b000}
  //   11: coprocessor/swi  -> 5'b0
  function automatic logic [6:0] decode_opcode(input logic [31:0] ir);
    logic [6:0] op;
    unique case (ir[ClassHi:ClassLo])
      2'b00:   op = {2'b00, ir[IBit], ir[PBit:WBit]};
      2'b01:   op = {2'b01, ir[IBit], ir[PBit], ir[UBit], ir[BBit], ir[SBit]};
      2'b10:   op = {2'b10, ir[IBit], ir[PBit], 3'b000};
      default: op = {2'b11, 5'b00000};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// 2-entry prefetch FIFO of {instruction word, word address}.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   flush_i           empty the queue (wins over push/pop)
//   push_i            write {word_i, addr_i}; caller guarantees not full
//   pop_i             drop the head; ignored when empty
//   word_o, addr_o    head entry, zero when empty
//   count_o           occupancy 0..2
module fetch_queue #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [31:0]       word_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       word_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        count_o
);

  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [31:0]       word0_q, word0_d, word1_q, word1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok;

  always_comb begin
    word0_d = word0_q;
    word1_d = word1_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != 2'd0);

    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_ok) begin
      if (count_q == 2'd2) begin
        word0_d = word1_q;
        addr0_d = addr1_q;
        word1_d = word_i;
        addr1_d = addr_i;
      end else begin
        word0_d = word_i;
        addr0_d = addr_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        word0_d = word_i;
        addr0_d = addr_i;
      end else begin
        word1_d = word_i;
        addr1_d = addr_i;
      end
      count_d = count_q + 2'd1;
    end else if (pop_ok) begin
      word0_d = word1_q;
      addr0_d = addr1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word0_q <= '0;
      word1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      count_q <= 2'd0;
    end else begin
      word0_q <= word0_d;
      word1_q <= word1_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      count_q <= count_d;
    end
  end

  assign word_o  = (count_q != 2'd0) ? word0_q : 32'd0;
  assign addr_o  = (count_q != 2'd0) ? addr0_q : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction RAM port 1 over a
// two-cycle F1/F2 access, buffers words in a 2-entry prefetch queue and
// presents the head plus decoded fields to the controller.
// Ports:
//   clk, rst               clock, async active-high reset
//   load_pc, sel_pc        redirect strobe and source (1 START_PC, 2 branch_addr)
//   branch_addr            branch target
//   ram_addr1              read address (= pc)
//   ram_rd_data1           read data, captured at end of F2
//   instr_valid/instr_ack  head-present / consume handshake
//   ir, instr_pc           head word and its address
//   opcode..imm24          fields decoded from ir (all 0 when queue empty)
//   fetch_busy             FSM in F1 or F2
module fetch_unit
  import arm_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_pc,
  input  logic [1:0]        sel_pc,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] ram_addr1,
  input  logic [31:0]       ram_rd_data1,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [6:0]        opcode,
  output logic [3:0]        cond,
  output logic              P,
  output logic              U,
  output logic              W,
  output logic              en_status_decode,
  output logic [1:0]        shift_op,
  output logic [3:0]        rn,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rm,
  output logic [11:0]       imm12,
  output logic [23:0]       imm24,
  output logic              fetch_busy
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              running_q, running_d;

  logic              redirect;
  logic              push;
  logic              pop;
  logic [1:0]        count;
  logic [1:0]        count_post;

  // Reserved and "ignore" encodings leave the PC alone.
  assign redirect = load_pc && ((sel_pc == SelStart) || (sel_pc == SelBranch));
  // An in-flight read is dropped on redirect; the queue flush also wins.
  assign push     = (state_q == StF2) && !redirect;
  assign pop      = instr_ack && instr_valid && !redirect;
  assign count_post = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    running_d = running_q;

    if (redirect) begin
      pc_d      = (sel_pc == SelStart) ? START_PC : branch_addr;
      running_d = 1'b1;
      state_d   = StF1;
    end else begin
      unique case (state_q)
        StIdle: if (running_q && (count != 2'd2)) state_d = StF1;
        StF1:   state_d = StF2;
        StF2: begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (count_post != 2'd2) ? StF1 : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= START_PC;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
    end
  end

  fetch_queue #(
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .word_i  (ram_rd_data1),
    .addr_i  (pc_q),
    .word_o  (ir),
    .addr_o  (instr_pc),
    .count_o (count)
  );

  assign ram_addr1   = pc_q;
  assign instr_valid = (count != 2'd0);
  assign fetch_busy  = (state_q == StF1) || (state_q == StF2);

  // ir is already zero when the queue is empty, so every field follows.
  assign opcode           = instr_valid ? decode_opcode(ir) : 7'd0;
  assign cond             = ir[CondHi:CondLo];
  assign P                = ir[PBit];
  assign U                = ir[UBit];
  assign W                = ir[WBit];
  assign en_status_decode = ir[SBit] & (ir[ClassHi:ClassLo] == 2'b00);
  assign shift_op         = ir[ShHi:ShLo];
  assign rn               = ir[RnHi:RnLo];
  assign rd               = ir[RdHi:RdLo];
  assign rs               = ir[RsHi:RsLo];
  assign rm               = ir[RmHi:RmLo];
  assign imm12            = ir[11:0];
  assign imm24            = ir[23:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_pc;
  logic [1:0]  sel_pc;
  logic [10:0] branch_addr;
  logic [10:0] ram_addr1;
  logic [31:0] ram_rd_data1;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] ir;
  logic [10:0] instr_pc;
  logic [6:0]  opcode;
  logic [3:0]  cond;
  logic        P, U, W;
  logic        en_status_decode;
  logic [1:0]  shift_op;
  logic [3:0]  rn, rd, rs, rm;
  logic [11:0] imm12;
  logic [23:0] imm24;
  logic        fetch_busy;

  logic [31:0] mem [2048];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ram_rd_data1 = mem[ram_addr1];

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .load_pc          (load_pc),
    .sel_pc           (sel_pc),
    .branch_addr      (branch_addr),
    .ram_addr1        (ram_addr1),
    .ram_rd_data1     (ram_rd_data1),
    .instr_valid      (instr_valid),
    .instr_ack        (instr_ack),
    .ir               (ir),
    .instr_pc         (instr_pc),
    .opcode           (opcode),
    .cond             (cond),
    .P                (P),
    .U                (U),
    .W                (W),
    .en_status_decode (en_status_decode),
    .shift_op         (shift_op),
    .rn               (rn),
    .rd               (rd),
    .rs               (rs),
    .rm               (rm),
    .imm12            (imm12),
    .imm24            (imm24),
    .fetch_busy       (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (one rising edge passes in between).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]      = 32'hE081_2000;
    mem[1]      = 32'hE59F_1004;
    mem[11'h40] = 32'h1234_5678;

    rst = 1'b1; load_pc = 1'b0; sel_pc = 2'd0; branch_addr = '0; instr_ack = 1'b0;
    step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_ir", ir, 0);
    chk("rst_addr", ram_addr1, 0);
    chk("rst_opcode", opcode, 0);
    rst = 1'b0;
    step(); step();
    chk("idle_no_fetch", fetch_busy, 0);

    // Start from START_PC.
    load_pc = 1'b1; sel_pc = 2'd1;
    step();                              // edge E
    load_pc = 1'b0; sel_pc = 2'd0;
    chk("f1_busy", fetch_busy, 1);
    chk("f1_valid", instr_valid, 0);
    step();                              // E+1
    chk("f2_valid", instr_valid, 0);
    step();                              // E+2
    chk("first_valid", instr_valid, 1);
    chk("first_ir", ir, 32'hE081_2000);
    chk("first_cond", cond, 4'hE);
    chk("first_rn", rn, 1);
    chk("first_rd", rd, 2);
    chk("first_rm", rm, 0);
    chk("first_shift", shift_op, 0);
    chk("first_pc", instr_pc, 0);
    chk("first_opcode", opcode, 7'h04);
    chk("first_s", en_status_decode, 0);
    chk("first_addr", ram_addr1, 1);
    step(); step();                      // E+4: queue full
    chk("full_busy", fetch_busy, 0);
    chk("full_addr", ram_addr1, 2);
    step();
    chk("full_hold_addr", ram_addr1, 2);
    chk("full_hold_busy", fetch_busy, 0);
    chk("full_head", ir, 32'hE081_2000);

    // One ack exposes RAM[1]; fetch of addr 2 resumes a cycle later.
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    chk("ack_ir", ir, 32'hE59F_1004);
    chk("ack_pc", instr_pc, 1);
    chk("ldr_P", P, 1);
    chk("ldr_U", U, 1);
    chk("ldr_W", W, 0);
    chk("ldr_rn", rn, 15);
    chk("ldr_rd", rd, 1);
    chk("ldr_imm12", imm12, 4);
    chk("ldr_s", en_status_decode, 0);
    chk("ldr_opcode", opcode, 7'h2D);
    chk("ldr_imm24", imm24, 24'h9F1004);
    chk("ack_busy", fetch_busy, 0);
    step();
    chk("resume_busy", fetch_busy, 1);
    chk("resume_addr", ram_addr1, 2);
    step();                              // now in F2

    // Redirect during F2 with a simultaneous ack: redirect wins.
    load_pc = 1'b1; sel_pc = 2'd2; branch_addr = 11'h040; instr_ack = 1'b1;
    step();
    load_pc = 1'b0; sel_pc = 2'd0; instr_ack = 1'b0;
    chk("br_flush_valid", instr_valid, 0);
    chk("br_addr", ram_addr1, 11'h040);
    chk("br_busy", fetch_busy, 1);
    step();
    chk("br_f2_valid", instr_valid, 0);
    step();
    chk("br_valid", instr_valid, 1);
    chk("br_ir", ir, 32'h1234_5678);
    chk("br_pc", instr_pc, 11'h040);

    // Wrap: target 0x7FF, acking every cycle.
    load_pc = 1'b1; sel_pc = 2'd2; branch_addr = 11'h7FF; instr_ack = 1'b1;
    step();
    load_pc = 1'b0; sel_pc = 2'd0;
    step();
    step();
    chk("wrap_valid0", instr_valid, 1);
    chk("wrap_pc0", instr_pc, 11'h7FF);
    chk("wrap_ir0", ir, 32'hA000_07FF);
    step();
    chk("wrap_popped", instr_valid, 0);
    step();
    chk("wrap_valid1", instr_valid, 1);
    chk("wrap_pc1", instr_pc, 0);
    chk("wrap_ir1", ir, 32'hE081_2000);
    chk("wrap_addr", ram_addr1, 1);
    instr_ack = 1'b0;

    // Reserved sel_pc is not a redirect.
    load_pc = 1'b1; sel_pc = 2'd3; branch_addr = 11'h123;
    step();                              // now in F2
    load_pc = 1'b0; sel_pc = 2'd0;
    chk("rsvd_valid", instr_valid, 1);
    chk("rsvd_pc", instr_pc, 0);
    chk("rsvd_addr", ram_addr1, 1);
    chk("rsvd_busy", fetch_busy, 1);

    // Asynchronous reset pulse between edges during F2.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_busy", fetch_busy, 0);
    chk("arst_ir", ir, 0);
    chk("arst_addr", ram_addr1, 0);
    #1 rst = 1'b0;
    step();
    chk("arst_no_push", instr_valid, 0);
    step(); step();
    chk("arst_idle_busy", fetch_busy, 0);
    chk("arst_idle_valid", instr_valid, 0);
    chk("arst_idle_addr", ram_addr1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
